// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg
// Shared types and helpers for the pipeline hazard / forwarding controller.
//   sb_entry_t  : one scoreboard slot {valid, rd, we, prod_stage}
//   FWD_RF      : forwarding select value meaning "read the register file"
//   fwd_width() : width of a forwarding select / stage index for N stages
// The rd and prod_stage fields are sized for the largest supported
// configuration (REG_ADDR_W <= 8, NUM_STAGES <= 255); narrower users
// zero-extend into them.
package pipe_hazard_pkg;

    localparam int SB_RD_W    = 8;
    localparam int SB_STAGE_W = 8;
    localparam int FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic [SB_RD_W-1:0]    rd;
        logic                  we;
        logic [SB_STAGE_W-1:0] prod_stage;
    } sb_entry_t;

    // Bits needed to encode 0..num_stages (0 = register file, k = stage k).
    function automatic int fwd_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/phc_scoreboard.sv
// phc_scoreboard
// Shifting scoreboard of in-flight destination registers for the stages
// after ID (stage 1 = EX ... stage NUM_STAGES = WB).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   advance             : shift the scoreboard this cycle (pipeline not frozen)
//   new_entry           : entry that enters stage 1 when advancing
//   rs_a/rs_b, *_used   : ID source registers to look up
//   hit_x               : some in-flight entry writes source x
//   hit_x_stage         : stage of the youngest such entry
//   hit_x_prod          : stage in which that entry's result becomes available
//   inflight_cnt        : number of valid entries
module phc_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int REG_ADDR_W    = 3,
    parameter int NUM_STAGES    = 3,
    parameter int ZERO_REG_FREE = 1,
    parameter int CNT_W         = fwd_width(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    input  sb_entry_t             new_entry,
    input  logic [REG_ADDR_W-1:0] rs_a,
    input  logic                  rs_a_used,
    input  logic [REG_ADDR_W-1:0] rs_b,
    input  logic                  rs_b_used,
    output logic                  hit_a,
    output logic [CNT_W-1:0]      hit_a_stage,
    output logic [SB_STAGE_W-1:0] hit_a_prod,
    output logic                  hit_b,
    output logic [CNT_W-1:0]      hit_b_stage,
    output logic [SB_STAGE_W-1:0] hit_b_prod,
    output logic [CNT_W-1:0]      inflight_cnt
);

    sb_entry_t sb [1:NUM_STAGES];

    // A slot is a producer for a source when it is a real, writing
    // instruction targeting that register. Register 0 is hardwired when
    // ZERO_REG_FREE is set, so it never creates a dependency.
    function automatic logic entry_hit(input sb_entry_t e,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic used);
        logic zero_skip;
        zero_skip = (ZERO_REG_FREE != 0) && (rs == '0);
        return used && e.valid && e.we && (e.rd == SB_RD_W'(rs)) && !zero_skip;
    endfunction

    // Shift register: on every non-frozen cycle each slot moves one stage
    // older, the WB slot falls off the end and the new entry lands in EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 1; s <= NUM_STAGES; s++) begin
                sb[s] <= '0;
            end
        end else if (advance) begin
            sb[1] <= new_entry;
            for (int s = 2; s <= NUM_STAGES; s++) begin
                sb[s] <= sb[s-1];
            end
        end
    end

    // Youngest-match search: scan from the oldest stage towards stage 1 so
    // that a younger hit overwrites any older one; the last writer wins.
    always_comb begin
        hit_a       = 1'b0;
        hit_a_stage = '0;
        hit_a_prod  = '0;
        hit_b       = 1'b0;
        hit_b_stage = '0;
        hit_b_prod  = '0;
        for (int s = NUM_STAGES; s >= 1; s--) begin
            if (entry_hit(sb[s], rs_a, rs_a_used)) begin
                hit_a       = 1'b1;
                hit_a_stage = CNT_W'(s);
                hit_a_prod  = sb[s].prod_stage;
            end
            if (entry_hit(sb[s], rs_b, rs_b_used)) begin
                hit_b       = 1'b1;
                hit_b_stage = CNT_W'(s);
                hit_b_prod  = sb[s].prod_stage;
            end
        end
    end

    // Population count of valid slots, including non-writing instructions.
    always_comb begin
        inflight_cnt = '0;
        for (int s = 1; s <= NUM_STAGES; s++) begin
            inflight_cnt = inflight_cnt + CNT_W'(sb[s].valid);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard detection and forwarding control for the pipelined core. Tracks
// in-flight destinations in a NUM_STAGES-deep scoreboard and produces
// registered forwarding selects plus same-cycle stall/flush/freeze control.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   id_valid                   : ID holds a real instruction
//   id_rs_a/b, id_rs_a/b_used  : ID source registers and whether they are read
//   id_rd, id_rd_we            : ID destination and its write enable
//   id_is_load                 : ID instruction is a load
//   branch_taken               : taken branch/jump resolved in EX
//   ext_stall                  : freeze the whole pipeline
//   fwd_a, fwd_b               : registered forwarding selects (0 = RF, k = stage k)
//   pc_hold, if_id_hold        : PC / IF-ID write disables
//   if_id_flush                : clear IF/ID
//   id_ex_bubble               : load a NOP into ID/EX
//   inflight_cnt               : number of valid scoreboard entries
// Optional build macro PHC_PERF_CNT_EN adds stall_cycles and flush_cnt,
// saturating 32-bit counters of non-frozen stall and branch-flush cycles.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_ADDR_W    = 3,
    parameter int NUM_STAGES    = 3,
    parameter int LOAD_LAT      = 2,
    parameter int ZERO_REG_FREE = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             id_valid,
    input  logic [REG_ADDR_W-1:0]            id_rs_a,
    input  logic [REG_ADDR_W-1:0]            id_rs_b,
    input  logic                             id_rs_a_used,
    input  logic                             id_rs_b_used,
    input  logic [REG_ADDR_W-1:0]            id_rd,
    input  logic                             id_rd_we,
    input  logic                             id_is_load,
    input  logic                             branch_taken,
    input  logic                             ext_stall,
    output logic [fwd_width(NUM_STAGES)-1:0] fwd_a,
    output logic [fwd_width(NUM_STAGES)-1:0] fwd_b,
    output logic                             pc_hold,
    output logic                             if_id_hold,
    output logic                             if_id_flush,
    output logic                             id_ex_bubble,
    output logic [fwd_width(NUM_STAGES)-1:0] inflight_cnt
`ifdef PHC_PERF_CNT_EN
    ,
    output logic [31:0]                      stall_cycles,
    output logic [31:0]                      flush_cnt
`endif
);

    localparam int FWD_W = fwd_width(NUM_STAGES);

    typedef struct packed {
        logic             stall;
        logic [FWD_W-1:0] sel;
    } fwd_dec_t;

    logic                  hit_a;
    logic                  hit_b;
    logic [FWD_W-1:0]      hit_a_stage;
    logic [FWD_W-1:0]      hit_b_stage;
    logic [SB_STAGE_W-1:0] hit_a_prod;
    logic [SB_STAGE_W-1:0] hit_b_prod;
    fwd_dec_t              dec_a;
    fwd_dec_t              dec_b;
    logic                  hazard_stall;
    logic                  frozen;
    logic                  issue;
    sb_entry_t             new_entry;

    // The consumer reaches EX one cycle from now, by which time the producer
    // found at stage s has moved to p = s+1. Past WB the value is already in
    // the register file; past its production stage it can be forwarded from
    // latch p; otherwise the consumer has to wait in ID.
    function automatic fwd_dec_t resolve(input logic hit,
                                         input logic [FWD_W-1:0] stage,
                                         input logic [SB_STAGE_W-1:0] prod);
        fwd_dec_t d;
        int       p;
        d.stall = 1'b0;
        d.sel   = FWD_W'(FWD_RF);
        if (hit) begin
            p = int'(stage) + 1;
            if (p > NUM_STAGES) begin
                d.sel = FWD_W'(FWD_RF);
            end else if (p > int'(prod)) begin
                d.sel = FWD_W'(p);
            end else begin
                d.stall = 1'b1;
            end
        end
        return d;
    endfunction

    phc_scoreboard #(
        .REG_ADDR_W    (REG_ADDR_W),
        .NUM_STAGES    (NUM_STAGES),
        .ZERO_REG_FREE (ZERO_REG_FREE),
        .CNT_W         (FWD_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .advance      (!frozen),
        .new_entry    (new_entry),
        .rs_a         (id_rs_a),
        .rs_a_used    (id_rs_a_used),
        .rs_b         (id_rs_b),
        .rs_b_used    (id_rs_b_used),
        .hit_a        (hit_a),
        .hit_a_stage  (hit_a_stage),
        .hit_a_prod   (hit_a_prod),
        .hit_b        (hit_b),
        .hit_b_stage  (hit_b_stage),
        .hit_b_prod   (hit_b_prod),
        .inflight_cnt (inflight_cnt)
    );

    // Per-source forwarding decision and the load-use stall it implies.
    // Only a real instruction in ID can stall the front end.
    always_comb begin
        dec_a        = resolve(hit_a, hit_a_stage, hit_a_prod);
        dec_b        = resolve(hit_b, hit_b_stage, hit_b_prod);
        hazard_stall = id_valid & (dec_a.stall | dec_b.stall);
    end

    // Pipeline control. A freeze dominates everything and suppresses flush
    // and bubble; a taken branch dominates a hazard because the ID
    // instruction is being discarded anyway.
    always_comb begin
        frozen       = ext_stall;
        issue        = !frozen & id_valid & !hazard_stall & !branch_taken;
        pc_hold      = frozen | (hazard_stall & !branch_taken);
        if_id_hold   = frozen | (hazard_stall & !branch_taken);
        if_id_flush  = !frozen & branch_taken;
        id_ex_bubble = !frozen & (branch_taken | hazard_stall);
    end

    // Entry pushed into stage 1: the ID instruction when it issues,
    // otherwise an all-zero (invalid) bubble.
    always_comb begin
        new_entry = '0;
        if (issue) begin
            new_entry.valid      = 1'b1;
            new_entry.rd         = SB_RD_W'(id_rd);
            new_entry.we         = id_rd_we;
            new_entry.prod_stage = id_is_load ? SB_STAGE_W'(LOAD_LAT) : SB_STAGE_W'(1);
        end
    end

    // Forwarding selects follow the instruction into EX, so they are
    // captured on the same edge that moves it there. A bubble or flush
    // carries no operands and gets the register-file select.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a <= FWD_W'(FWD_RF);
            fwd_b <= FWD_W'(FWD_RF);
        end else if (!frozen) begin
            fwd_a <= issue ? dec_a.sel : FWD_W'(FWD_RF);
            fwd_b <= issue ? dec_b.sel : FWD_W'(FWD_RF);
        end
    end

`ifdef PHC_PERF_CNT_EN
    // Saturating performance counters; frozen cycles are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cnt    <= '0;
        end else if (!frozen) begin
            if (hazard_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
